// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_RD_WAIT
    } arb_state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_IO
    } arb_owner_e;

    localparam int ARB_CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between pipeline memory stage, IO/DMA master, arbiter and dmem.
// The arbiter takes the slave view; the surrounding wrapper takes the master view.
interface dmem_arbiter_if;

    logic        cpu_req;
    logic        cpu_wren;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_data;
    logic        cpu_stall;
    logic [31:0] cpu_q;

    logic        io_req;
    logic        io_wren;
    logic [31:0] io_addr;
    logic [31:0] io_data;
    logic        io_gnt;
    logic        io_rvalid;
    logic [31:0] io_q;

    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_wren;
    logic [31:0] mem_q;

    modport slave (
        input  cpu_req, cpu_wren, cpu_addr, cpu_data,
        output cpu_stall, cpu_q,
        input  io_req, io_wren, io_addr, io_data,
        output io_gnt, io_rvalid, io_q,
        output mem_addr, mem_data, mem_wren,
        input  mem_q
    );

    modport master (
        output cpu_req, cpu_wren, cpu_addr, cpu_data,
        input  cpu_stall, cpu_q,
        output io_req, io_wren, io_addr, io_data,
        input  io_gnt, io_rvalid, io_q,
        input  mem_addr, mem_data, mem_wren,
        output mem_q
    );

endinterface

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating count of contested IDLE cycles the IO master has lost;
// force_io tells the arbiter to hand the next contested grant to IO.
module dmem_arb_starve_ctr
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic force_io
);

    localparam logic [ARB_CNT_W-1:0] WAIT_LIMIT = ARB_CNT_W'(MAX_WAIT);

    logic [ARB_CNT_W-1:0] wait_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (inc && (wait_cnt != WAIT_LIMIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign force_io = (wait_cnt == WAIT_LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port dmem arbiter: CPU memory stage has priority over one IO master.
// Optional IO starvation guard is compiled in with DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic           clock,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);

    localparam int LAT_W = $clog2(RD_LAT + 1);

    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
        $error("dmem_arbiter: RD_LAT must be within 1..4");
    end
    if (MAX_WAIT < 1 || MAX_WAIT > 15) begin : g_bad_max_wait
        $error("dmem_arbiter: MAX_WAIT must be within 1..15");
    end

    arb_state_e       state_q, state_d;
    arb_owner_e       owner_q, owner_d;
    logic [31:0]      addr_q, addr_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             io_rvalid_q;
    logic [31:0]      io_q_q;

    logic             grant_cpu, grant_io, rd_done;
    logic             cpu_done, io_done;
    logic             force_io;
    logic [31:0]      mem_addr_c, mem_data_c;
    logic             mem_wren_c;

    // Grant selection, dmem steering and read sequencing
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        lat_d      = lat_q;
        grant_cpu  = 1'b0;
        grant_io   = 1'b0;
        rd_done    = 1'b0;
        mem_addr_c = bus.cpu_addr;
        mem_data_c = bus.cpu_data;
        mem_wren_c = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (!reset) begin
                    if (bus.cpu_req && !(bus.io_req && force_io)) begin
                        grant_cpu = 1'b1;
                    end else if (bus.io_req) begin
                        grant_io = 1'b1;
                    end
                end

                if (grant_io) begin
                    mem_addr_c = bus.io_addr;
                    mem_data_c = bus.io_data;
                    mem_wren_c = bus.io_wren;
                end else if (grant_cpu) begin
                    mem_wren_c = bus.cpu_wren;
                end

                if ((grant_cpu && !bus.cpu_wren) || (grant_io && !bus.io_wren)) begin
                    state_d = ARB_RD_WAIT;
                    owner_d = grant_io ? OWN_IO : OWN_CPU;
                    addr_d  = grant_io ? bus.io_addr : bus.cpu_addr;
                    lat_d   = LAT_W'(1);
                end
            end

            ARB_RD_WAIT: begin
                // Address stays pinned to the latched value for the whole read
                mem_addr_c = addr_q;
                if (lat_q == LAT_W'(RD_LAT)) begin
                    rd_done = 1'b1;
                    state_d = ARB_IDLE;
                    lat_d   = '0;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end

            default: state_d = ARB_IDLE;
        endcase
    end

    assign cpu_done = rd_done && (owner_q == OWN_CPU);
    assign io_done  = rd_done && (owner_q == OWN_IO);

`ifdef DMEM_ARB_STARVE_GUARD_EN
    logic wait_inc, wait_clr;

    // Only contested IDLE cycles lost by IO count toward the bound
    assign wait_inc = (state_q == ARB_IDLE) && bus.cpu_req && bus.io_req && grant_cpu;
    assign wait_clr = grant_io || !bus.io_req;

    dmem_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clock    (clock),
        .reset    (reset),
        .inc      (wait_inc),
        .clr      (wait_clr),
        .force_io (force_io)
    );
`else
    assign force_io = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_CPU;
            addr_q      <= '0;
            lat_q       <= '0;
            io_rvalid_q <= 1'b0;
            io_q_q      <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            lat_q       <= lat_d;
            io_rvalid_q <= io_done;
            if (io_done) begin
                io_q_q <= bus.mem_q;
            end
        end
    end

    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_data  = mem_data_c;
    assign bus.mem_wren  = mem_wren_c;

    // A CPU request is released only by its own store grant or read completion
    assign bus.cpu_stall = bus.cpu_req && !reset &&
                           !((grant_cpu && bus.cpu_wren) || cpu_done);
    assign bus.cpu_q     = cpu_done ? bus.mem_q : 32'h0;

    assign bus.io_gnt    = grant_io;
    assign bus.io_rvalid = io_rvalid_q;
    assign bus.io_q      = io_q_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: two instances (RD_LAT=1 and RD_LAT=2),
// each backed by a small combinational-read memory model.
module tb_dmem_arbiter;

    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    dmem_arbiter_if bus1 ();
    dmem_arbiter_if bus2 ();

    dmem_arbiter #(.RD_LAT(1), .MAX_WAIT(4)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.slave)
    );

    dmem_arbiter #(.RD_LAT(2), .MAX_WAIT(4)) u_dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2.slave)
    );

    logic [31:0] mem1 [0:255];
    logic [31:0] mem2 [0:255];

    always @(posedge clock) begin
        if (bus1.mem_wren) mem1[bus1.mem_addr[9:2]] <= bus1.mem_data;
        if (bus2.mem_wren) mem2[bus2.mem_addr[9:2]] <= bus2.mem_data;
    end

    assign bus1.mem_q = mem1[bus1.mem_addr[9:2]];
    assign bus2.mem_q = mem2[bus2.mem_addr[9:2]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_all();
        bus1.cpu_req = 1'b0; bus1.cpu_wren = 1'b0; bus1.cpu_addr = '0; bus1.cpu_data = '0;
        bus1.io_req  = 1'b0; bus1.io_wren  = 1'b0; bus1.io_addr  = '0; bus1.io_data  = '0;
        bus2.cpu_req = 1'b0; bus2.cpu_wren = 1'b0; bus2.cpu_addr = '0; bus2.cpu_data = '0;
        bus2.io_req  = 1'b0; bus2.io_wren  = 1'b0; bus2.io_addr  = '0; bus2.io_data  = '0;
    endtask

    initial begin
        logic guard;
        logic exp_g;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        reset = 1'b1;
        idle_all();

        // Requests present while reset is held must be masked
        bus1.cpu_req = 1'b1; bus1.cpu_wren = 1'b1; bus1.cpu_addr = 32'h10;
        bus1.io_req  = 1'b1;
        #3;
        chk("rst_cpu_stall", {31'b0, bus1.cpu_stall}, 32'h0);
        chk("rst_io_gnt",    {31'b0, bus1.io_gnt},    32'h0);
        chk("rst_mem_wren",  {31'b0, bus1.mem_wren},  32'h0);
        chk("rst_io_rvalid", {31'b0, bus1.io_rvalid}, 32'h0);
        chk("rst_io_q",      bus1.io_q,               32'h0);
        repeat (2) nxt();
        idle_all();
        reset = 1'b0;

        // CPU store, RD_LAT=1: same-cycle write, no stall
        bus1.cpu_req = 1'b1; bus1.cpu_wren = 1'b1; bus1.cpu_addr = 32'h10; bus1.cpu_data = 32'hDEAD;
        #3;
        chk("st_mem_wren",  {31'b0, bus1.mem_wren},  32'h1);
        chk("st_mem_addr",  bus1.mem_addr,           32'h10);
        chk("st_mem_data",  bus1.mem_data,           32'hDEAD);
        chk("st_cpu_stall", {31'b0, bus1.cpu_stall}, 32'h0);
        nxt();
        idle_all();

        // CPU store then load, RD_LAT=2: two stall cycles, address latched
        bus2.cpu_req = 1'b1; bus2.cpu_wren = 1'b1; bus2.cpu_addr = 32'h20; bus2.cpu_data = 32'h1234;
        #3;
        chk("ld2_st_stall", {31'b0, bus2.cpu_stall}, 32'h0);
        nxt();
        bus2.cpu_wren = 1'b0;
        #3;
        chk("ld2_c0_stall",    {31'b0, bus2.cpu_stall}, 32'h1);
        chk("ld2_c0_mem_wren", {31'b0, bus2.mem_wren},  32'h0);
        chk("ld2_c0_mem_addr", bus2.mem_addr,           32'h20);
        nxt();
        bus2.cpu_addr = 32'h24;
        #3;
        chk("ld2_c1_stall",    {31'b0, bus2.cpu_stall}, 32'h1);
        chk("ld2_c1_mem_addr", bus2.mem_addr,           32'h20);
        chk("ld2_c1_cpu_q",    bus2.cpu_q,              32'h0);
        nxt();
        #3;
        chk("ld2_c2_stall", {31'b0, bus2.cpu_stall}, 32'h0);
        chk("ld2_c2_cpu_q", bus2.cpu_q,              32'h1234);
        nxt();
        idle_all();

        // IO store then IO load with a CPU request arriving behind it, RD_LAT=1
        bus1.io_req = 1'b1; bus1.io_wren = 1'b1; bus1.io_addr = 32'h40; bus1.io_data = 32'hBEEF;
        #3;
        chk("iost_gnt",      {31'b0, bus1.io_gnt},   32'h1);
        chk("iost_mem_wren", {31'b0, bus1.mem_wren}, 32'h1);
        chk("iost_mem_addr", bus1.mem_addr,          32'h40);
        chk("iost_mem_data", bus1.mem_data,          32'hBEEF);
        nxt();
        bus1.io_wren = 1'b0;
        #3;
        chk("iold_t_gnt",      {31'b0, bus1.io_gnt},    32'h1);
        chk("iold_t_mem_wren", {31'b0, bus1.mem_wren},  32'h0);
        chk("iold_t_rvalid",   {31'b0, bus1.io_rvalid}, 32'h0);
        nxt();
        bus1.io_req = 1'b0;
        bus1.cpu_req = 1'b1; bus1.cpu_wren = 1'b0; bus1.cpu_addr = 32'h10;
        #3;
        chk("iold_t1_cpu_stall", {31'b0, bus1.cpu_stall}, 32'h1);
        chk("iold_t1_gnt",       {31'b0, bus1.io_gnt},    32'h0);
        chk("iold_t1_rvalid",    {31'b0, bus1.io_rvalid}, 32'h0);
        chk("iold_t1_mem_addr",  bus1.mem_addr,           32'h40);
        nxt();
        #3;
        chk("iold_t2_rvalid",    {31'b0, bus1.io_rvalid}, 32'h1);
        chk("iold_t2_io_q",      bus1.io_q,               32'hBEEF);
        chk("iold_t2_cpu_stall", {31'b0, bus1.cpu_stall}, 32'h1);
        chk("iold_t2_mem_addr",  bus1.mem_addr,           32'h10);
        nxt();
        #3;
        chk("iold_t3_rvalid",    {31'b0, bus1.io_rvalid}, 32'h0);
        chk("iold_t3_io_q_hold", bus1.io_q,               32'hBEEF);
        chk("iold_t3_cpu_stall", {31'b0, bus1.cpu_stall}, 32'h0);
        chk("iold_t3_cpu_q",     bus1.cpu_q,              32'hDEAD);
        nxt();
        idle_all();

        // Continuous contention: CPU stores vs IO stores
        bus1.cpu_req = 1'b1; bus1.cpu_wren = 1'b1; bus1.cpu_addr = 32'h80; bus1.cpu_data = 32'hC0;
        bus1.io_req  = 1'b1; bus1.io_wren  = 1'b1; bus1.io_addr  = 32'h84; bus1.io_data  = 32'h55;
        for (int i = 0; i < 10; i++) begin
            #3;
            exp_g = guard && (i == 4 || i == 9);
            chk($sformatf("cont%0d_io_gnt", i),    {31'b0, bus1.io_gnt},    {31'b0, exp_g});
            chk($sformatf("cont%0d_cpu_stall", i), {31'b0, bus1.cpu_stall}, {31'b0, exp_g});
            chk($sformatf("cont%0d_mem_addr", i),  bus1.mem_addr,           exp_g ? 32'h84 : 32'h80);
            nxt();
        end
        bus1.cpu_req = 1'b0;
        #3;
        chk("cont_release_io_gnt",   {31'b0, bus1.io_gnt},   32'h1);
        chk("cont_release_mem_addr", bus1.mem_addr,          32'h84);
        nxt();
        idle_all();

        // Reset during the RD_WAIT of an IO load drops the read
        bus1.io_req = 1'b1; bus1.io_wren = 1'b0; bus1.io_addr = 32'h40;
        #3;
        chk("rstrd_gnt", {31'b0, bus1.io_gnt}, 32'h1);
        nxt();
        reset = 1'b1;
        bus1.io_req = 1'b0;
        bus1.cpu_req = 1'b1; bus1.cpu_wren = 1'b0; bus1.cpu_addr = 32'h40;
        #3;
        chk("rstrd_cpu_stall", {31'b0, bus1.cpu_stall}, 32'h0);
        chk("rstrd_io_gnt",    {31'b0, bus1.io_gnt},    32'h0);
        chk("rstrd_mem_wren",  {31'b0, bus1.mem_wren},  32'h0);
        chk("rstrd_io_rvalid", {31'b0, bus1.io_rvalid}, 32'h0);
        chk("rstrd_io_q",      bus1.io_q,               32'h0);
        nxt();
        reset = 1'b0;
        #3;
        chk("post_rst_rvalid",    {31'b0, bus1.io_rvalid}, 32'h0);
        chk("post_rst_io_q",      bus1.io_q,               32'h0);
        chk("post_rst_cpu_stall", {31'b0, bus1.cpu_stall}, 32'h1);
        chk("post_rst_mem_addr",  bus1.mem_addr,           32'h40);
        nxt();
        #3;
        chk("post_rst_ld_stall",  {31'b0, bus1.cpu_stall}, 32'h0);
        chk("post_rst_ld_cpu_q",  bus1.cpu_q,              32'hBEEF);
        chk("post_rst_ld_rvalid", {31'b0, bus1.io_rvalid}, 32'h0);
        nxt();
        idle_all();
        bus1.io_req = 1'b1; bus1.io_wren = 1'b0; bus1.io_addr = 32'h10;
        #3;
        chk("post_rst_io_gnt", {31'b0, bus1.io_gnt}, 32'h1);
        nxt();
        bus1.io_req = 1'b0;
        nxt();
        #3;
        chk("post_rst_io_rvalid", {31'b0, bus1.io_rvalid}, 32'h1);
        chk("post_rst_io_q",      bus1.io_q,               32'hDEAD);
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
